// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with lock support and read tagging.
// Optional macro BRAM_ARB_RSP_REG_EN registers rsp_valid/rsp_rdata once more (read latency 3 instead of 2).
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18,
    parameter int MAX_LOCK   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          REN,
    output logic                          WEN,
    output logic [ADDR_WIDTH-1:0]         ADDR,
    output logic [DATA_WIDTH-1:0]         WDATA,
    input  logic [DATA_WIDTH-1:0]         RDATA
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_next;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      scan_idx;
    logic               gnt;
    logic [7:0]         lock_cnt;
    logic [8:0]         lock_inc;
    logic               keep_lock;
    logic [PW-1:0]      cmd_tag;
    logic [PW-1:0]      rsp_tag;
    logic               rsp_pend;
    logic [NUM_REQ-1:0] rsp_oh;

    // Rotating search starting at ptr; first valid requester wins.
    always_comb begin
        gnt      = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!gnt && req_valid[scan_idx]) begin
                gnt     = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt = gnt & reset_n;
    end

    always_comb begin
        req_ready = '0;
        if (gnt) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign lock_inc  = {1'b0, lock_cnt} + 9'd1;
    assign keep_lock = req_lock[gnt_idx] && (lock_inc < 9'(MAX_LOCK));
    assign ptr_next  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            lock_cnt <= '0;
            REN      <= 1'b0;
            WEN      <= 1'b0;
            ADDR     <= '0;
            WDATA    <= '0;
            cmd_tag  <= '0;
            rsp_pend <= 1'b0;
            rsp_tag  <= '0;
        end else begin
            // REN doubles as the read-pending flag of the command stage.
            rsp_pend <= REN;
            rsp_tag  <= cmd_tag;
            if (gnt) begin
                REN     <= ~req_we[gnt_idx];
                WEN     <= req_we[gnt_idx];
                ADDR    <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                WDATA   <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                cmd_tag <= gnt_idx;
                if (keep_lock) begin
                    ptr      <= gnt_idx;
                    lock_cnt <= lock_inc[7:0];
                end else begin
                    ptr      <= ptr_next;
                    lock_cnt <= '0;
                end
            end else begin
                REN      <= 1'b0;
                WEN      <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

    assign rsp_oh = rsp_pend ? (NUM_REQ'(1) << rsp_tag) : '0;

`ifdef BRAM_ARB_RSP_REG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rsp_oh;
            rsp_rdata <= rsp_pend ? RDATA : '0;
        end
    end
`else
    assign rsp_valid = rsp_oh;
    assign rsp_rdata = rsp_pend ? RDATA : '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: cycle-level reference model plus directed literal checks.
module tb_bram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 18;
    localparam int MAX_LOCK = 8;
`ifdef BRAM_ARB_RSP_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            REN;
    logic            WEN;
    logic [AW-1:0]   ADDR;
    logic [DW-1:0]   WDATA;
    logic [DW-1:0]   RDATA = '0;

    bram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .REN(REN), .WEN(WEN), .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA)
    );

    always #5 clk = ~clk;

    // BRAM port: one-cycle registered read
    logic [DW-1:0] bmem [1024];
    always @(posedge clk) begin
        if (WEN) bmem[ADDR] <= WDATA;
        if (REN) RDATA <= bmem[ADDR];
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: command history in acceptance order
    typedef struct {
        bit            v;
        bit            we;
        int            tag;
        logic [DW-1:0] rdata;
    } ev_t;

    ev_t           pipe [4];
    int            m_ptr = 0;
    int            m_lcnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] mmem [1024];

    function automatic int model_grant();
        if (!reset_n) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ptr = 0;
            m_lcnt = 0;
            m_addr = '0;
            m_wdata = '0;
            for (int k = 0; k < 4; k++) pipe[k].v = 1'b0;
        end else begin
            int  g;
            ev_t e;
            g = model_grant();
            e.v = 1'b0; e.we = 1'b0; e.tag = 0; e.rdata = '0;
            if (g >= 0) begin
                e.v = 1'b1;
                e.we = req_we[g];
                e.tag = g;
                m_addr = req_addr[g*AW +: AW];
                m_wdata = req_wdata[g*DW +: DW];
                if (e.we) mmem[m_addr] = m_wdata;
                else e.rdata = mmem[m_addr];
                if (req_lock[g] && (m_lcnt + 1 < MAX_LOCK)) begin
                    m_ptr = g;
                    m_lcnt = m_lcnt + 1;
                end else begin
                    m_ptr = (g + 1) % N;
                    m_lcnt = 0;
                end
            end else begin
                m_lcnt = 0;
            end
            for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = e;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("m_ready_rst", req_ready, 0);
            chk("m_ren_rst", REN, 0);
            chk("m_wen_rst", WEN, 0);
            chk("m_addr_rst", ADDR, 0);
            chk("m_wdata_rst", WDATA, 0);
            chk("m_rsp_valid_rst", rsp_valid, 0);
            chk("m_rsp_rdata_rst", rsp_rdata, 0);
        end else begin
            int          g;
            logic [31:0] exp_rv;
            g = model_grant();
            chk("m_ready", req_ready, (g < 0) ? 0 : (32'd1 << g));
            chk("m_ren", REN, pipe[0].v && !pipe[0].we);
            chk("m_wen", WEN, pipe[0].v && pipe[0].we);
            chk("m_addr", ADDR, m_addr);
            chk("m_wdata", WDATA, m_wdata);
            exp_rv = (pipe[LAT-1].v && !pipe[LAT-1].we) ? (32'd1 << pipe[LAT-1].tag) : 0;
            chk("m_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 0) chk("m_rsp_rdata", rsp_rdata, pipe[LAT-1].rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0;
        req_we = '0;
        req_lock = '0;
    endtask

    task automatic set_req(input int i, input bit we, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_lock[i] = lk;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        clr();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic [N-1:0] got [11];
    logic [N-1:0] lock_exp [11];

    initial begin
        for (int a = 0; a < 1024; a++) begin
            bmem[a] = 18'h15000 | DW'(a);
            mmem[a] = 18'h15000 | DW'(a);
        end
        lock_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                     4'b1000, 4'b0001, 4'b0010};

        // reset holds ready low even with requests pending
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_ren", REN, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        clr();

        // single read by requester 2
        tick();
        set_req(2, 1'b0, 1'b0, 10'h005, 18'h0);
        @(negedge clk);
        chk("rd_ready", req_ready, 4'b0100);
        tick();
        clr();
        @(negedge clk);
        chk("rd_ren", REN, 1);
        chk("rd_addr", ADDR, 10'h005);
        repeat (LAT - 1) tick();
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rsp_rdata", rsp_rdata, 18'h15005);

        // round robin, all requesting
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(10'h010 + i), DW'(18'h3A000 + i));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got[k] = req_ready;
            tick();
        end
        clr();
        for (int k = 0; k < 8; k++) chk($sformatf("rr_grant%0d", k), got[k], 4'b0001 << (k % 4));
        repeat (LAT + 1) tick();

        // lock bound: move ptr to 1, then 1 locks against 0 and 3
        set_req(0, 1'b0, 1'b0, 10'h020, 18'h0);
        @(negedge clk);
        chk("lock_prime", req_ready, 4'b0001);
        tick();
        clr();
        set_req(0, 1'b0, 1'b0, 10'h020, 18'h0);
        set_req(1, 1'b0, 1'b1, 10'h021, 18'h0);
        set_req(3, 1'b0, 1'b0, 10'h023, 18'h0);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            got[k] = req_ready;
            tick();
        end
        clr();
        for (int k = 0; k < 11; k++) chk($sformatf("lock_grant%0d", k), got[k], lock_exp[k]);
        tick();

        // write then read same address
        set_req(0, 1'b1, 1'b0, 10'h001, 18'h55001);
        @(negedge clk);
        chk("wr_ready", req_ready, 4'b0001);
        tick();
        clr();
        set_req(3, 1'b0, 1'b0, 10'h001, 18'h0);
        @(negedge clk);
        chk("wr2rd_ready", req_ready, 4'b1000);
        chk("wr_wen", WEN, 1);
        chk("wr_wdata", WDATA, 18'h55001);
        tick();
        clr();
        @(negedge clk);
        chk("wr2rd_ren", REN, 1);
        chk("wr2rd_wen", WEN, 0);
        repeat (LAT - 1) tick();
        @(negedge clk);
        chk("wr2rd_rsp_valid", rsp_valid, 4'b1000);
        chk("wr2rd_rsp_rdata", rsp_rdata, 18'h55001);
        repeat (LAT + 1) tick();

        // reset in the middle of back-to-back reads
        set_req(1, 1'b0, 1'b0, 10'h0A1, 18'h2A0A1);
        set_req(2, 1'b0, 1'b0, 10'h0B2, 18'h2B0B2);
        repeat (3) tick();
        reset_n = 1'b0;
        #2;
        chk("arst_ren", REN, 0);
        chk("arst_wen", WEN, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_ready", req_ready, 0);
        tick();
        tick();
        reset_n = 1'b1;
        clr();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("no_stale%0d", k), rsp_valid, 0);
            tick();
        end
        set_req(1, 1'b0, 1'b0, 10'h0A1, 18'h2A0A1);
        set_req(2, 1'b0, 1'b0, 10'h0B2, 18'h2B0B2);
        @(negedge clk);
        chk("first_after_reset", req_ready, 4'b0010);
        tick();
        clr();

        // idle: command outputs hold, pointer unchanged
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("idle_ren%0d", k), REN, 0);
            chk($sformatf("idle_wen%0d", k), WEN, 0);
            tick();
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(10'h040 + i), DW'(18'h0));
        @(negedge clk);
        chk("idle_addr_hold", ADDR, 10'h0A1);
        chk("idle_wdata_hold", WDATA, 18'h2A0A1);
        chk("idle_ptr_kept", req_ready, 4'b0100);
        tick();
        clr();
        repeat (LAT + 1) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of a qlf_k6n10f 18K true-dual-port BRAM half (one REN/WEN/ADDR/WDATA/RDATA set) among NUM_REQ requesters. It accepts one read or write command per cycle and registers it onto the BRAM port. It tracks which requester each read belongs to and returns the read data with a one-hot response strobe. It sits between client logic and a dpram_* wrapper port, one instance per BRAM port.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 10: BRAM port address width.
- DATA_WIDTH, 18: BRAM port data width.
- MAX_LOCK, 8: maximum consecutive grants to one requester while it holds req_lock (1..255).

- clk  in  1  single clock; also drives the BRAM port clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  command request per requester.
- req_ready  out  NUM_REQ  one-hot grant; command accepted when req_valid[i] & req_ready[i].
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  request to keep priority after this grant.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  out  DATA_WIDTH  read data for the requester flagged in rsp_valid.
- REN  out  1  BRAM read enable.
- WEN  out  1  BRAM write enable.
- ADDR  out  ADDR_WIDTH  BRAM address.
- WDATA  out  DATA_WIDTH  BRAM write data.
- RDATA  in  DATA_WIDTH  BRAM read data, valid the cycle after the REN sample edge.

## Operation
- Priority pointer `ptr` (0..NUM_REQ-1) selects the highest-priority requester. The search runs ptr, ptr+1, … modulo NUM_REQ. The first requester with req_valid set gets req_ready. There is at most one grant per cycle.
- req_ready is combinational from req_valid, ptr and the lock state, and is forced to 0 while reset_n is low.
- On each grant to requester g:
  - If req_lock[g]=1 and lock_cnt+1 < MAX_LOCK: ptr stays g and lock_cnt increments.
  - Otherwise ptr becomes (g+1) mod NUM_REQ and lock_cnt becomes 0.
- A cycle with no grant leaves ptr unchanged and clears lock_cnt.
- Command stage (registered): on a grant, REN = ~req_we[g] and WEN = req_we[g]. ADDR and WDATA load from slice g. With no grant, REN=WEN=0 and ADDR/WDATA hold their last value.
- Read tracking: the command-stage register captures tag = g and a read-pending flag. One cycle later, rsp_valid = onehot(tag) and rsp_rdata = RDATA.
- Writes produce no response.
- A read immediately after a write to the same address returns the newly written data, because the accesses are in different cycles.
- Reset (async assert, sync release by the caller):
  - ptr=0, lock_cnt=0.
  - REN=0, WEN=0, ADDR=0, WDATA=0.
  - rsp_valid=0, rsp_rdata=0.
  - In-flight reads are discarded and never responded to.

## Timing
- Accept in cycle N. REN/WEN/ADDR/WDATA are driven during N+1 and sampled by the BRAM at the end of N+1.
- rsp_valid/rsp_rdata are driven during N+2: read latency is 2 cycles (3 with the option below).
- Full throughput: one command per cycle, sustained indefinitely. Back-to-back reads from different requesters return in grant order, one per cycle.
- Pointer and lock updates take effect on the cycle after the grant.
- Reset asserted mid-burst: all outputs clear immediately and asynchronously. After release, arbitration restarts at requester 0.

## Configuration
- BRAM_ARB_RSP_REG_EN
  - Defined: rsp_valid and rsp_rdata pass through one extra output register. Read latency becomes 3 cycles, and the extra registers reset to 0.
  - Undefined: rsp_rdata is combinational from RDATA, with 2-cycle latency.
  - Arbitration and command timing are identical in both builds.

## Test plan
- Single read: reset, then requester 2 reads addr 0x005, where the BRAM holds 0x15005 → req_ready=4'b0100 in N; REN=1, ADDR=0x005 in N+1; rsp_valid=4'b0100, rsp_rdata=0x15005 in N+2 (N+3 with BRAM_ARB_RSP_REG_EN).
- Round robin: all four req_valid held high, no lock → grants 0,1,2,3,0,1… on consecutive cycles with no idle cycles.
- Lock bound: MAX_LOCK=8, requester 1 holds valid+lock while 0 and 3 also request → requester 1 gets exactly 8 consecutive grants, then 2-index search grants 3, then 0.
- Write/read ordering: requester 0 writes 0x55001 to addr 0x001, then requester 3 reads addr 0x001 the next cycle → WEN then REN on consecutive cycles; rsp_valid=4'b1000, rsp_rdata=0x55001.
- Reset mid-operation: reset_n pulled low during back-to-back reads → REN, WEN and rsp_valid go to 0 immediately with no stale response after release. First grant after release goes to the lowest-indexed valid requester.
- Idle: no req_valid for 10 cycles → REN=WEN=0 and ADDR/WDATA hold their values; ptr is unchanged.
